// File: rtl/seq_mult_if.sv
// rtl/seq_mult_if.sv - start/done handshake and result bundle for seq_mult
interface seq_mult_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     dataa;
  logic [WIDTH-1:0]     datab;
  logic [2*WIDTH-1:0]   product;
  logic                 done;
  logic                 busy;
  logic                 err;
  logic [2:0]           state_out;

  modport master (
    output start, dataa, datab,
    input  product, done, busy, err, state_out
  );

  modport slave (
    input  start, dataa, datab,
    output product, done, busy, err, state_out
  );
endinterface

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - digit-serial unsigned multiplier; SEQ_MULT_ZERO_SKIP_EN skips CALC for zero operands
module seq_mult #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic     clk,
  input  logic     reset_a_n,
  seq_mult_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int NSQ = NCH * NCH;
  localparam int CW  = $clog2(NSQ);
  localparam int AW  = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(NSQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [AW-1:0]      acc;
  logic [CW-1:0]      cnt;

  logic [CW-1:0]      dig_i;
  logic [CW-1:0]      dig_j;
  logic [CHUNK-1:0]   a_dig;
  logic [CHUNK-1:0]   b_dig;
  logic [2*CHUNK-1:0] mul;
  logic [AW-1:0]      pp;
  logic [AW-1:0]      acc_sum;
  logic               launch;
  logic               zero_op;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign zero_op = (bus.dataa == '0) || (bus.datab == '0);
`else
  assign zero_op = 1'b0;
`endif

  // A start from any non-CALC state loads a new operation; in CALC it aborts instead.
  assign launch = bus.start && (state != CALC);

  // Select the current digit pair, multiply, and align the partial product.
  always_comb begin
    dig_i   = CW'(32'(cnt) / NCH);
    dig_j   = CW'(32'(cnt) % NCH);
    a_dig   = CHUNK'(opa >> (dig_i * CHUNK));
    b_dig   = CHUNK'(opb >> (dig_j * CHUNK));
    mul     = {{CHUNK{1'b0}}, a_dig} * {{CHUNK{1'b0}}, b_dig};
    pp      = AW'(mul) << ((dig_i + dig_j) * CHUNK);
    acc_sum = acc + pp;
  end

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      state         <= IDLE;
      opa           <= '0;
      opb           <= '0;
      acc           <= '0;
      cnt           <= '0;
      bus.product   <= '0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
      bus.state_out <= 3'd0;
    end else if (launch) begin
      opa      <= bus.dataa;
      opb      <= bus.datab;
      acc      <= '0;
      cnt      <= '0;
      bus.err  <= 1'b0;
      if (zero_op) begin
        bus.product   <= '0;
        state         <= DONE;
        bus.done      <= 1'b1;
        bus.busy      <= 1'b0;
        bus.state_out <= 3'd2;
      end else begin
        state         <= CALC;
        bus.done      <= 1'b0;
        bus.busy      <= 1'b1;
        bus.state_out <= 3'd1;
      end
    end else begin
      case (state)
        CALC: begin
          if (bus.start) begin
            state         <= ERR;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b1;
            bus.state_out <= 3'd3;
          end else if (cnt == LAST) begin
            acc           <= acc_sum;
            bus.product   <= acc_sum;
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.state_out <= 3'd2;
          end else begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.done      <= 1'b0;
          bus.state_out <= 3'd0;
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end
endmodule
